term_src_fifo: RTL

TERM_SRC_FIFO -- requirements
Module: term_src_fifo

---
 rtl/term_src_fifo_pkg.sv | 24 ++
 rtl/term_fifo_mem.sv | 23 ++
 rtl/term_src_fifo.sv | 109 ++++++++++
 3 files changed

// File: rtl/term_src_fifo_pkg.sv
// Shared definitions for the mesh terminal source FIFO: header layout and counter width.
package term_src_fifo_pkg;

  localparam int unsigned ROW_W = 4;
  localparam int unsigned COL_W = 4;

  // Header bit positions, expressed as offsets below pckg_sz
  localparam int unsigned ROW_HI_OFS = 9;
  localparam int unsigned ROW_LO_OFS = 12;
  localparam int unsigned COL_HI_OFS = 13;
  localparam int unsigned COL_LO_OFS = 16;
  localparam int unsigned MODE_OFS   = 17;

  localparam int unsigned STAT_W = 8;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             mode;
  } hdr_t;

  localparam int unsigned HDR_W = $bits(hdr_t);

endpackage

// File: rtl/term_fifo_mem.sv
// Dual-pointer FIFO storage: one synchronous write port, asynchronous read of the head slot.
module term_fifo_mem #(
  parameter int unsigned width = 40,
  parameter int unsigned depth = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] waddr,
  input  logic [width-1:0]         wdata,
  input  logic [$clog2(depth)-1:0] raddr,
  output logic [width-1:0]         rdata
);

  logic [width-1:0] mem [depth];

  // Storage is deliberately not reset; validity is tracked by the owner's pointers
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/term_src_fifo.sv
// Source-side FIFO feeding a mesh terminal: screens destination addresses,
// buffers packets first-word-fall-through and keeps saturating loss counters.
module term_src_fifo
  import term_src_fifo_pkg::*;
#(
  parameter int unsigned rows    = 4,
  parameter int unsigned columns = 4,
  parameter int unsigned pckg_sz = 40,
  parameter int unsigned f_depth = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [pckg_sz-1:0]           push_data,
  output logic                         full,
  output logic                         pndng_i_in,
  output logic [pckg_sz-1:0]           data_out_i_in,
  input  logic                         popin,
  output logic [$clog2(f_depth+1)-1:0] count,
  output logic [STAT_W-1:0]            ovf_cnt,
  output logic [STAT_W-1:0]            drop_cnt
);

  localparam int unsigned PTR_W   = $clog2(f_depth);
  localparam int unsigned CNT_W   = $clog2(f_depth+1);
  localparam int unsigned ROW_MAX = rows + 1;
  localparam int unsigned COL_MAX = columns + 1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  hdr_t               hdr;
  logic               unused_mode;
  logic               addr_ok_c;
  logic               pop_c;
  logic               wr_en_c;
  logic               ovf_inc_c;
  logic               drop_inc_c;
  logic [CNT_W-1:0]   cnt_nxt_c;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [pckg_sz-1:0] rd_data;
  logic [pckg_sz-1:0] hold_q;

  // Row, col and mode sit contiguously just below the top byte
  assign hdr         = hdr_t'(push_data[pckg_sz-ROW_HI_OFS -: HDR_W]);
  assign unused_mode = hdr.mode;

  always_comb begin
    addr_ok_c  = 1'b0;
    pop_c      = 1'b0;
    wr_en_c    = 1'b0;
    ovf_inc_c  = 1'b0;
    drop_inc_c = 1'b0;
    cnt_nxt_c  = count;

    addr_ok_c  = (32'(hdr.row) <= ROW_MAX) && (32'(hdr.col) <= COL_MAX);
    pop_c      = popin & pndng_i_in;
    // A same-cycle pop frees the slot, so a full FIFO can still accept
    wr_en_c    = push & addr_ok_c & (~full | pop_c);
    ovf_inc_c  = push & addr_ok_c & full & ~pop_c;
    drop_inc_c = push & ~addr_ok_c;

    case ({wr_en_c, pop_c})
      2'b10:   cnt_nxt_c = count + CNT_W'(1);
      2'b01:   cnt_nxt_c = count - CNT_W'(1);
      default: cnt_nxt_c = count;
    endcase
  end

  // Pointers, occupancy, flags and loss counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      pndng_i_in <= 1'b0;
      ovf_cnt    <= '0;
      drop_cnt   <= '0;
      hold_q     <= '0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        hold_q <= rd_data;
      end
      count      <= cnt_nxt_c;
      full       <= (cnt_nxt_c == CNT_W'(f_depth));
      pndng_i_in <= (cnt_nxt_c != '0);
      if (ovf_inc_c && (ovf_cnt != STAT_MAX))   ovf_cnt  <= ovf_cnt + STAT_W'(1);
      if (drop_inc_c && (drop_cnt != STAT_MAX)) drop_cnt <= drop_cnt + STAT_W'(1);
    end
  end

  term_fifo_mem #(
    .width (pckg_sz),
    .depth (f_depth)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en_c),
    .waddr (wr_ptr),
    .wdata (push_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // When empty, keep presenting the most recently consumed head
  assign data_out_i_in = pndng_i_in ? rd_data : hold_q;

endmodule
